// File: rtl/seg_scan_drv.sv
// seg_scan_drv: multi-digit time-multiplexed hex 7-segment scanner with double-buffered, frame-synchronous updates
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   load       capture data_in/dp_in/blank_in into the pending buffer
//   data_in    DIGITS nibbles, digit 0 in bits 3:0
//   dp_in      per-digit decimal point
//   blank_in   per-digit blank (segments and DP off)
//   seg_out    {dp, g..a}, registered, polarity set by SEG_ACT_LOW
//   dig_out    one-hot digit enable, registered, polarity set by DIG_ACT_LOW
//   frame_done one-cycle pulse after each frame's last cycle
//   Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_drv #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_out,
    output logic                  frame_done
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [DW-1:0]       div_q, div_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_data_q, disp_data_q;
    logic [DIGITS-1:0]   pend_dp_q, pend_blank_q, disp_dp_q, disp_blank_q;
    logic                pend_valid_q, pend_valid_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_done_q;
    logic                div_tc, commit;
    logic [DIGITS-1:0]   lzb;
    logic [3:0]          nib;
    logic                cur_dp, cur_blank, cur_lzb;
    assign div_tc = div_q == DW'(SCAN_DIV - 1);
    assign commit = div_tc && idx_q == IW'(DIGITS - 1);
    always_comb begin
        div_d        = div_tc ? '0 : div_q + 1'b1;
        idx_d        = !div_tc ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        // A load in the commit cycle keeps pending valid for the next frame.
        pend_valid_d = load || (pend_valid_q && !commit);
    end
`ifdef SEG_SCAN_LZB_EN
    logic hi_zero;
    // Walk from the top digit down; a zero is suppressed while everything above it is zero or blank.
    always_comb begin
        hi_zero = 1'b1;
        lzb     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lzb[k]  = (k != 0) && hi_zero && disp_data_q[4*k +: 4] == 4'h0;
            hi_zero = hi_zero && (disp_data_q[4*k +: 4] == 4'h0 || disp_blank_q[k]);
        end
    end
`else
    assign lzb = '0;
`endif
    always_comb begin
        nib       = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lzb   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib       = disp_data_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = disp_blank_q[k];
                cur_lzb   = lzb[k];
            end
        end
        // Explicit blank kills the DP too; leading-zero blanking leaves the DP alone.
        seg_d = cur_blank ? 8'h00 : {cur_dp, cur_lzb ? 7'h00 : SEG_LUT[nib]};
        // Slot position 0 is dead-time: segments settle while no digit is driven.
        dig_d = div_q == '0 ? '0 : DIGITS'(1) << idx_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
            seg_q        <= '0;
            dig_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= commit;
            if (commit && pend_valid_q) begin
                disp_data_q  <= pend_data_q;
                disp_dp_q    <= pend_dp_q;
                disp_blank_q <= pend_blank_q;
            end
            if (load) begin
                pend_data_q  <= data_in;
                pend_dp_q    <= dp_in;
                pend_blank_q <= blank_in;
            end
        end
    end
    assign seg_out    = seg_q ^ {8{SEG_ACT_LOW}};
    assign dig_out    = dig_q ^ {DIGITS{DIG_ACT_LOW}};
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: directed frame-by-frame checks of seg_scan_drv with DIGITS=4, SCAN_DIV=4
module tb_seg_scan_drv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [7:0]  seg_out;
    logic [3:0]  dig_out;
    logic        frame_done;
    int checks = 0;
    int failures = 0;
`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    seg_scan_drv #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .seg_out(seg_out), .dig_out(dig_out), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [23:0] w;
        logic [31:0] s;
    } vec_t;
    vec_t vecs [7];
    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got seg=%h dig=%b fd=%b expected seg=%h dig=%b fd=%b",
                     nm, act[12:5], act[4:1], act[0], exp[12:5], exp[4:1], exp[0]);
        end
    endtask
    // One full frame starting at a frame boundary; s = {d3,d2,d1,d0} segment words,
    // optional loads of word {data,dp,blank} at slot positions la and lb.
    task automatic frame(input string nm, input logic [31:0] s,
                         input int la, input logic [23:0] wa, input int lb, input logic [23:0] wb);
        for (int p = 0; p < 16; p++) begin
            load = (p == la) || (p == lb);
            if (p == la) {data_in, dp_in, blank_in} = wa;
            if (p == lb) {data_in, dp_in, blank_in} = wb;
            @(negedge clk);
            chk($sformatf("%s p%0d", nm, p), {seg_out, dig_out, frame_done},
                {s[8*(p/4) +: 8], (p % 4 == 0) ? 4'hF : ~(4'b0001 << (p/4)), p == 15});
        end
        load = 1'b0;
    endtask
    initial begin
        vecs[0] = '{{16'h12AF, 4'b0000, 4'b0000}, 32'h065B7771};
        vecs[1] = '{{16'h0000, 4'b0001, 4'b0100}, LZB ? 32'h000000BF : 32'h3F003FBF};
        vecs[2] = '{{16'h0050, 4'b0000, 4'b0000}, LZB ? 32'h00006D3F : 32'h3F3F6D3F};
        vecs[3] = '{{16'h89CD, 4'b1010, 4'b0000}, 32'hFF6FB95E};
        vecs[4] = '{{16'h4567, 4'b0000, 4'b1001}, 32'h006D7D00};
        vecs[5] = '{{16'hE0B3, 4'b0000, 4'b0000}, 32'h793F7C4F};
        vecs[6] = '{{16'h0074, 4'b0000, 4'b0000}, LZB ? 32'h00000766 : 32'h3F3F0766};
        repeat (3) @(negedge clk);
        chk("reset", {seg_out, dig_out, frame_done}, {8'h00, 4'hF, 1'b0});
        rst_n = 1'b1;
        frame("dark", 32'h0, 0, vecs[0].w, -1, '0);
        for (int i = 1; i < 7; i++)
            frame($sformatf("vec%0d", i - 1), vecs[i-1].s, 0, vecs[i].w, -1, '0);
        frame("vec6 midload", vecs[6].s, 5, {16'h3333, 8'h00}, -1, '0);
        frame("all3", 32'h4F4F4F4F, 3, vecs[0].w, 15, vecs[3].w);
        frame("pre-commit data", vecs[0].s, -1, '0, -1, '0);
        frame("commit-cycle data", vecs[3].s, 15, vecs[5].w, -1, '0);
        frame("no commit", vecs[3].s, -1, '0, -1, '0);
        frame("late commit", vecs[5].s, 2, vecs[4].w, 9, vecs[6].w);
        frame("last load wins", vecs[6].s, -1, '0, -1, '0);
        for (int p = 0; p < 6; p++) begin
            load = (p == 2);
            {data_in, dp_in, blank_in} = vecs[3].w;
            @(negedge clk);
        end
        load = 1'b0;
        chk("pre mid reset", {seg_out, dig_out, frame_done}, {vecs[6].s[15:8], 4'b1101, 1'b0});
        #2 rst_n = 1'b0;
        #1 chk("mid reset", {seg_out, dig_out, frame_done}, {8'h00, 4'hF, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        frame("dark after reset", 32'h0, -1, '0, -1, '0);
        frame("pending cleared", 32'h0, -1, '0, -1, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
